// File: rtl/instr_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// instr_loader
//
// Program loader that writes instruction words into instruction memory. It
// receives a byte stream over a valid/ready handshake: a 16-bit word-count
// header (high byte first) followed by that many instruction words (high byte
// first). Each byte pair is assembled into one WORD_SIZE word and written to
// consecutive memory addresses starting at BASE_ADDR, one write per word.
// Completion is flagged on `done` so the core can be released from hold.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a load (honoured only in IDLE or DONE)
//   in_byte        stream byte
//   in_valid       in_byte is valid
//   in_ready       loader accepts a byte this cycle
//   mem_addr       registered write address
//   mem_data       registered write data
//   mem_we         write strobe, one cycle per word
//   busy           load in progress
//   done           last load completed; held until the next accepted start
//   words_written  words written in the current or last load
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int          WORD_SIZE = 16,
    parameter int          BYTE_SIZE = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [BYTE_SIZE-1:0] in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_data,
    output logic                 mem_we,
    output logic                 busy,
    output logic                 done,
    output logic [WORD_SIZE-1:0] words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [WORD_SIZE-1:0] BASE = WORD_SIZE'(BASE_ADDR);
    localparam logic [WORD_SIZE-1:0] ONE  = WORD_SIZE'(1);

    state_t                 state_q,         state_d;
    logic [WORD_SIZE-1:0]   len_q,           len_d;
    logic [BYTE_SIZE-1:0]   word_hi_q,       word_hi_d;
    logic [WORD_SIZE-1:0]   addr_q,          addr_d;
    logic [WORD_SIZE-1:0]   mem_addr_q,      mem_addr_d;
    logic [WORD_SIZE-1:0]   mem_data_q,      mem_data_d;
    logic [WORD_SIZE-1:0]   words_written_q, words_written_d;

    logic                   accept;
    logic [WORD_SIZE-1:0]   len_full;
    logic [WORD_SIZE-1:0]   written_next;

    // Handshake-facing outputs are decoded from state only, so in_ready has
    // no combinational dependence on in_valid.
    assign in_ready      = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                           (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
    assign mem_we        = (state_q == S_WRITE);
    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done          = (state_q == S_DONE);
    assign mem_addr      = mem_addr_q;
    assign mem_data      = mem_data_q;
    assign words_written = words_written_q;

    assign accept        = in_valid && in_ready;
    // Length as it will read once the low header byte lands this cycle.
    assign len_full      = {len_q[WORD_SIZE-1:BYTE_SIZE], in_byte};
    assign written_next  = words_written_q + ONE;

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        word_hi_d       = word_hi_q;
        addr_d          = addr_q;
        mem_addr_d      = mem_addr_q;
        mem_data_d      = mem_data_q;
        words_written_d = words_written_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d         = S_LEN_HI;
                    words_written_d = '0;
                    addr_d          = BASE;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {in_byte, len_q[BYTE_SIZE-1:0]};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d   = len_full;
                    state_d = (len_full == '0) ? S_DONE : S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (accept) begin
                    word_hi_d = in_byte;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                // Stage the write registers now so they are stable for the
                // whole WRITE cycle.
                if (accept) begin
                    mem_data_d = {word_hi_q, in_byte};
                    mem_addr_d = addr_q;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wraps silently at 2^WORD_SIZE.
                addr_d          = addr_q + ONE;
                words_written_d = written_next;
                state_d         = (written_next == len_q) ? S_DONE : S_DATA_HI;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            len_q           <= '0;
            word_hi_q       <= '0;
            addr_q          <= '0;
            mem_addr_q      <= '0;
            mem_data_q      <= '0;
            words_written_q <= '0;
        end else begin
            state_q         <= state_d;
            len_q           <= len_d;
            word_hi_q       <= word_hi_d;
            addr_q          <= addr_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_q      <= mem_data_d;
            words_written_q <= words_written_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
`timescale 1ns/1ps
module tb_instr_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;

    logic        in_ready, mem_we, busy, done;
    logic [15:0] mem_addr, mem_data, words_written;

    logic        w_in_ready, w_mem_we, w_busy, w_done;
    logic [15:0] w_mem_addr, w_mem_data, w_words_written;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_in_write = 0;

    logic [15:0] wa[$];
    logic [15:0] wd[$];
    logic [15:0] xa[$];
    logic [15:0] xd[$];

    instr_loader #(.WORD_SIZE(16), .BYTE_SIZE(8), .BASE_ADDR(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte),
        .in_valid(in_valid), .in_ready(in_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_we(mem_we), .busy(busy), .done(done),
        .words_written(words_written)
    );

    // Same stream, different base: used for the address wrap case.
    instr_loader #(.WORD_SIZE(16), .BYTE_SIZE(8), .BASE_ADDR(32'h0000_FFFF)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte),
        .in_valid(in_valid), .in_ready(w_in_ready), .mem_addr(w_mem_addr),
        .mem_data(w_mem_data), .mem_we(w_mem_we), .busy(w_busy), .done(w_done),
        .words_written(w_words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write log, sampled mid-cycle; a strobe longer than one cycle is logged twice.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            if (in_ready) rdy_in_write <= rdy_in_write + 1;
        end
        if (w_mem_we) begin
            xa.push_back(w_mem_addr);
            xd.push_back(w_mem_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic load(input byte_q_t bq, input bit stall);
        foreach (bq[i]) begin
            if (stall) begin
                in_valid = 1'b0;
                in_byte  = 8'hXX;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            send(bq[i]);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", 32'(done), 32'd1);
    endtask

    initial begin
        int base, xbase, c0, c1;
        byte_q_t bq;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_data", 32'(mem_data), 0);
        chk("rst_words", 32'(words_written), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(in_ready), 0);

        // Reset mid-load: header 0x0003 and one data byte, then async reset
        base = wa.size();
        do_start();
        chk("start_ready", 32'(in_ready), 1);
        chk("start_busy", 32'(busy), 1);
        bq = '{8'h00, 8'h03, 8'h12};
        load(bq, 1'b0);
        chk("partial_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_ready", 32'(in_ready), 0);
        chk("async_done", 32'(done), 0);
        chk("async_we", 32'(mem_we), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abandon_no_write", 32'(wa.size()), 32'(base));

        // Basic load after reset: 00 03 12 34 AB CD 00 01
        base = wa.size();
        do_start();
        send(8'h00);
        c0 = cyc;
        bq = '{8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
        load(bq, 1'b0);
        wait_done();
        c1 = cyc;
        // 11 cycles from the first header byte's cycle = 10 edges later
        chk("load_time", 32'(c1 - c0), 32'd10);
        chk("basic_nwr", 32'(wa.size() - base), 3);
        if (wa.size() - base == 3) begin
            chk("basic_a0", 32'(wa[base]), 32'h0000);
            chk("basic_d0", 32'(wd[base]), 32'h1234);
            chk("basic_a1", 32'(wa[base+1]), 32'h0001);
            chk("basic_d1", 32'(wd[base+1]), 32'hABCD);
            chk("basic_a2", 32'(wa[base+2]), 32'h0002);
            chk("basic_d2", 32'(wd[base+2]), 32'h0001);
        end
        chk("basic_words", 32'(words_written), 3);
        chk("basic_busy", 32'(busy), 0);
        chk("basic_ready", 32'(in_ready), 0);
        chk("hold_addr", 32'(mem_addr), 32'h0002);
        chk("hold_data", 32'(mem_data), 32'h0001);

        // Zero length
        base = wa.size();
        do_start();
        chk("zero_done_clr", 32'(done), 0);
        chk("zero_words_clr", 32'(words_written), 0);
        send(8'h00);
        send(8'h00);
        in_valid = 1'b0;
        chk("zero_done", 32'(done), 1);
        chk("zero_words", 32'(words_written), 0);
        chk("zero_nwr", 32'(wa.size()), 32'(base));

        // Stalled 4-word load with an ignored start pulse in the middle
        base = wa.size();
        do_start();
        bq = '{8'h00, 8'h04, 8'hC0, 8'hDE, 8'h0F, 8'h0F};
        load(bq, 1'b1);
        do_start();
        chk("ign_start_busy", 32'(busy), 1);
        chk("ign_start_words", 32'(words_written), 2);
        bq = '{8'h80, 8'h01, 8'h7F, 8'hFE};
        load(bq, 1'b1);
        wait_done();
        chk("stall_nwr", 32'(wa.size() - base), 4);
        if (wa.size() - base == 4) begin
            chk("stall_a0", 32'(wa[base]), 32'h0000);
            chk("stall_d0", 32'(wd[base]), 32'hC0DE);
            chk("stall_a1", 32'(wa[base+1]), 32'h0001);
            chk("stall_d1", 32'(wd[base+1]), 32'h0F0F);
            chk("stall_a2", 32'(wa[base+2]), 32'h0002);
            chk("stall_d2", 32'(wd[base+2]), 32'h8001);
            chk("stall_a3", 32'(wa[base+3]), 32'h0003);
            chk("stall_d3", 32'(wd[base+3]), 32'h7FFE);
        end
        chk("stall_words", 32'(words_written), 4);

        // Address wrap on the BASE_ADDR=0xFFFF instance
        xbase = xa.size();
        do_start();
        bq = '{8'h00, 8'h02, 8'hAA, 8'h55, 8'h5A, 8'hA5};
        load(bq, 1'b0);
        wait_done();
        chk("wrap_nwr", 32'(xa.size() - xbase), 2);
        if (xa.size() - xbase == 2) begin
            chk("wrap_a0", 32'(xa[xbase]), 32'hFFFF);
            chk("wrap_d0", 32'(xd[xbase]), 32'hAA55);
            chk("wrap_a1", 32'(xa[xbase+1]), 32'h0000);
            chk("wrap_d1", 32'(xd[xbase+1]), 32'h5AA5);
        end
        chk("wrap_words", 32'(w_words_written), 2);
        chk("wrap_done", 32'(w_done), 1);

        // Reload after DONE
        base = wa.size();
        do_start();
        chk("reload_done_clr", 32'(done), 0);
        bq = '{8'h00, 8'h01, 8'hBE, 8'hEF};
        load(bq, 1'b0);
        wait_done();
        chk("reload_nwr", 32'(wa.size() - base), 1);
        if (wa.size() - base == 1) begin
            chk("reload_a0", 32'(wa[base]), 32'h0000);
            chk("reload_d0", 32'(wd[base]), 32'hBEEF);
        end
        chk("reload_words", 32'(words_written), 1);

        chk("ready_in_write", 32'(rdy_in_write), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
